// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA sequencer that sits between the core,
// the scratchpad SRAM and external DRAM.
package dma_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    DMA_NONE = 2'b00,
    DMA_D2S  = 2'b01,
    DMA_S2D  = 2'b10
  } dma_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    D2S_REQ,
    D2S_WAIT,
    S2D_REQ,
    DONE
  } dma_state_e;

  // Only the two transfer encodings start a job; 2'b11 is reserved and ignored.
  function automatic logic isTransferCmd(input logic [1:0] cmd);
    return (cmd == DMA_D2S) || (cmd == DMA_S2D);
  endfunction

endpackage

// File: rtl/dma_sram_arbiter.sv
// Single SRAM port mux: the core owns the port while the sequencer is idle,
// the DMA engine owns it otherwise (which also blocks core writes).
module dma_sram_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              dmaSelect_i,
  input  logic [ADDR_W-1:0] cpuAddress_i,
  input  logic [31:0]       cpuWriteData_i,
  input  logic              cpuWriteEnable_i,
  input  logic [ADDR_W-1:0] dmaAddress_i,
  input  logic [31:0]       dmaWriteData_i,
  input  logic              dmaWriteEnable_i,
  output logic [ADDR_W-1:0] sramAddress_o,
  output logic [31:0]       sramWriteData_o,
  output logic              sramWriteEnable_o
);

  assign sramAddress_o     = dmaSelect_i ? dmaAddress_i     : cpuAddress_i;
  assign sramWriteData_o   = dmaSelect_i ? dmaWriteData_i   : cpuWriteData_i;
  assign sramWriteEnable_o = dmaSelect_i ? dmaWriteEnable_i : cpuWriteEnable_i;

endmodule

// File: rtl/dma_ctrl.sv
// DMA sequencer: freezes the core and moves words DRAM->SRAM or SRAM->DRAM,
// one DRAM request per word, owning the SRAM port for the duration.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int WIDTH_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         dmaCmd,
  input  logic [ADDR_W-1:0]  dmaSrcAddress,
  input  logic [ADDR_W-1:0]  dmaDstAddress,
  input  logic [WIDTH_W-1:0] dmaWidth,
  output logic               stall,
  input  logic [ADDR_W-1:0]  cpuSramAddress,
  input  logic [31:0]        cpuSramWriteData,
  input  logic               cpuSramWriteEnable,
  output logic [31:0]        cpuSramReadData,
  output logic [ADDR_W-1:0]  sramAddress,
  output logic [31:0]        sramWriteData,
  output logic               sramWriteEnable,
  input  logic [31:0]        sramReadData,
  output logic               dramReq,
  output logic               dramWrite,
  output logic [ADDR_W-1:0]  dramAddress,
  output logic [31:0]        dramWriteData,
  input  logic               dramReady,
  input  logic               dramReadValid,
  input  logic [31:0]        dramReadData
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] PTR_STEP   = ADDR_W'(WORD_BYTES);

  dma_state_e         state_q;
  logic [ADDR_W-1:0]  srcPtr_q;
  logic [ADDR_W-1:0]  dstPtr_q;
  logic [WIDTH_W-1:0] remain_q;
  logic               dramReq_q;
  logic               dramWrite_q;

  logic               startXfer;
  logic               lastBeat;
  logic [ADDR_W-1:0]  dmaSramAddress;
  logic               dmaSramWriteEnable;

  assign startXfer = isTransferCmd(dmaCmd);
  assign lastBeat  = (remain_q == WIDTH_W'(1));

  // DRAM request/direction are registered and always agree with the REQ states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      srcPtr_q    <= '0;
      dstPtr_q    <= '0;
      remain_q    <= '0;
      dramReq_q   <= 1'b0;
      dramWrite_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (startXfer) begin
            srcPtr_q <= dmaSrcAddress & ALIGN_MASK;
            dstPtr_q <= dmaDstAddress & ALIGN_MASK;
            remain_q <= dmaWidth;
            if (dmaWidth == '0) begin
              state_q <= DONE;
            end else if (dmaCmd == DMA_D2S) begin
              state_q     <= D2S_REQ;
              dramReq_q   <= 1'b1;
              dramWrite_q <= 1'b0;
            end else begin
              state_q     <= S2D_REQ;
              dramReq_q   <= 1'b1;
              dramWrite_q <= 1'b1;
            end
          end
        end
        D2S_REQ: begin
          if (dramReady) begin
            state_q   <= D2S_WAIT;
            dramReq_q <= 1'b0;
          end
        end
        D2S_WAIT: begin
          if (dramReadValid) begin
            srcPtr_q <= srcPtr_q + PTR_STEP;
            dstPtr_q <= dstPtr_q + PTR_STEP;
            remain_q <= remain_q - WIDTH_W'(1);
            if (lastBeat) begin
              state_q <= DONE;
            end else begin
              state_q   <= D2S_REQ;
              dramReq_q <= 1'b1;
            end
          end
        end
        S2D_REQ: begin
          if (dramReady) begin
            srcPtr_q <= srcPtr_q + PTR_STEP;
            dstPtr_q <= dstPtr_q + PTR_STEP;
            remain_q <= remain_q - WIDTH_W'(1);
            if (lastBeat) begin
              state_q     <= DONE;
              dramReq_q   <= 1'b0;
              dramWrite_q <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          dramReq_q   <= 1'b0;
          dramWrite_q <= 1'b0;
        end
      endcase
    end
  end

  // The IDLE term freezes the core in the very cycle the command is presented.
  assign stall = ((state_q != IDLE) && (state_q != DONE)) ||
                 ((state_q == IDLE) && startXfer);

  assign dramReq   = dramReq_q;
  assign dramWrite = dramWrite_q;

  always_comb begin
    dramAddress   = '0;
    dramWriteData = '0;
    if (state_q == D2S_REQ) begin
      dramAddress = srcPtr_q;
    end else if (state_q == S2D_REQ) begin
      dramAddress   = dstPtr_q;
      dramWriteData = sramReadData;
    end
  end

  assign dmaSramAddress     = (state_q == D2S_WAIT) ? dstPtr_q : srcPtr_q;
  assign dmaSramWriteEnable = (state_q == D2S_WAIT) && dramReadValid;

  dma_sram_arbiter #(
    .ADDR_W(ADDR_W)
  ) uArbiter (
    .dmaSelect_i       (state_q != IDLE),
    .cpuAddress_i      (cpuSramAddress),
    .cpuWriteData_i    (cpuSramWriteData),
    .cpuWriteEnable_i  (cpuSramWriteEnable),
    .dmaAddress_i      (dmaSramAddress),
    .dmaWriteData_i    (dramReadData),
    .dmaWriteEnable_i  (dmaSramWriteEnable),
    .sramAddress_o     (sramAddress),
    .sramWriteData_o   (sramWriteData),
    .sramWriteEnable_o (sramWriteEnable)
  );

  assign cpuSramReadData = sramReadData;

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: behavioural SRAM/DRAM models plus per-scenario tasks that
// push expected writes into scoreboards and compare them against logged traffic.
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  dmaCmd = 2'b00;
  logic [31:0] dmaSrcAddress = '0;
  logic [31:0] dmaDstAddress = '0;
  logic [9:0]  dmaWidth = '0;
  logic        stall;
  logic [31:0] cpuSramAddress = '0;
  logic [31:0] cpuSramWriteData = '0;
  logic        cpuSramWriteEnable = 1'b0;
  logic [31:0] cpuSramReadData;
  logic [31:0] sramAddress;
  logic [31:0] sramWriteData;
  logic        sramWriteEnable;
  logic [31:0] sramReadData;
  logic        dramReq;
  logic        dramWrite;
  logic [31:0] dramAddress;
  logic [31:0] dramWriteData;
  logic        dramReady;
  logic        dramReadValid = 1'b0;
  logic [31:0] dramReadData = '0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expSramQ[$];
  wr_t         expDramQ[$];
  wr_t         obsSramQ[$];
  wr_t         obsDramQ[$];
  logic [31:0] stallAddrQ[$];
  logic [31:0] sramMem[256];
  logic [31:0] dramMem[256];
  bit          memInit = 1'b0;
  int          stallSeen = 0;
  int          readyAt = 0;
  int          acceptCnt = 0;
  int          reqCycles = 0;
  int          nChecks = 0;
  int          nPass = 0;

  dma_ctrl #(.ADDR_W(32), .WIDTH_W(10)) dut (
    .clk                (clk),
    .reset              (reset),
    .dmaCmd             (dmaCmd),
    .dmaSrcAddress      (dmaSrcAddress),
    .dmaDstAddress      (dmaDstAddress),
    .dmaWidth           (dmaWidth),
    .stall              (stall),
    .cpuSramAddress     (cpuSramAddress),
    .cpuSramWriteData   (cpuSramWriteData),
    .cpuSramWriteEnable (cpuSramWriteEnable),
    .cpuSramReadData    (cpuSramReadData),
    .sramAddress        (sramAddress),
    .sramWriteData      (sramWriteData),
    .sramWriteEnable    (sramWriteEnable),
    .sramReadData       (sramReadData),
    .dramReq            (dramReq),
    .dramWrite          (dramWrite),
    .dramAddress        (dramAddress),
    .dramWriteData      (dramWriteData),
    .dramReady          (dramReady),
    .dramReadValid      (dramReadValid),
    .dramReadData       (dramReadData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sramInit(input int i);
    return 32'h5A00_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] dramInit(input int i);
    return 32'hD000_0000 + 32'(i * 3);
  endfunction

  assign sramReadData = sramMem[sramAddress[9:2]];
  assign dramReady    = (stallSeen >= readyAt);

  // SRAM and DRAM models; every accepted write is logged for the scoreboards.
  always @(posedge clk) begin : memModel
    dramReadValid <= 1'b0;
    if (!memInit) begin
      for (int i = 0; i < 256; i++) begin
        sramMem[i] = sramInit(i);
        dramMem[i] = dramInit(i);
      end
      memInit = 1'b1;
    end
    if (dramReq) begin
      reqCycles++;
      if (!dramReady) begin
        stallSeen <= stallSeen + 1;
        stallAddrQ.push_back(dramAddress);
      end else begin
        acceptCnt++;
        if (dramWrite) begin
          obsDramQ.push_back({dramAddress, dramWriteData});
          dramMem[dramAddress[9:2]] = dramWriteData;
        end else begin
          dramReadValid <= 1'b1;
          dramReadData  <= dramMem[dramAddress[9:2]];
        end
      end
    end
    if (sramWriteEnable) begin
      obsSramQ.push_back({sramAddress, sramWriteData});
      sramMem[sramAddress[9:2]] = sramWriteData;
    end
  end

  // Issues one command and holds until stall drops; leaves the FSM back in IDLE.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] src,
                               input logic [31:0] dst, input logic [9:0] width,
                               input bit coreWe, output int stallCycles,
                               output bit timedOut);
    @(negedge clk);
    dmaCmd        = cmd;
    dmaSrcAddress = src;
    dmaDstAddress = dst;
    dmaWidth      = width;
    stallCycles   = 0;
    timedOut      = 1'b0;
    #1;
    while (stall) begin
      stallCycles++;
      if (stallCycles > 200) begin
        timedOut = 1'b1;
        break;
      end
      @(negedge clk);
      dmaCmd             = 2'b00;
      cpuSramWriteEnable = coreWe;
      #1;
    end
    dmaCmd             = 2'b00;
    cpuSramWriteEnable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cpuSramAddress     = 32'h44;
    cpuSramWriteData   = 32'h1234_5678;
    cpuSramWriteEnable = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    nChecks++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall); else nPass++;
    nChecks++; if (dramReq !== 1'b0) $display("[TB] FAIL reset_dramReq: got %b expected 0", dramReq); else nPass++;
    nChecks++; if (dramWrite !== 1'b0) $display("[TB] FAIL reset_dramWrite: got %b expected 0", dramWrite); else nPass++;
    nChecks++; if (dramAddress !== 32'h0) $display("[TB] FAIL reset_dramAddress: got %h expected 0", dramAddress); else nPass++;
    nChecks++; if (dramWriteData !== 32'h0) $display("[TB] FAIL reset_dramWriteData: got %h expected 0", dramWriteData); else nPass++;
    nChecks++; if (sramAddress !== 32'h44) $display("[TB] FAIL reset_sramAddress: got %h expected 44", sramAddress); else nPass++;
    nChecks++; if (sramWriteData !== 32'h1234_5678) $display("[TB] FAIL reset_sramWriteData: got %h expected 12345678", sramWriteData); else nPass++;
    nChecks++; if (sramWriteEnable !== 1'b0) $display("[TB] FAIL reset_sramWriteEnable: got %b expected 0", sramWriteEnable); else nPass++;
    nChecks++; if (cpuSramReadData !== sramInit(17)) $display("[TB] FAIL reset_cpuReadData: got %h expected %h", cpuSramReadData, sramInit(17)); else nPass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    nChecks++; if (stall !== 1'b0) $display("[TB] FAIL post_reset_stall: got %b expected 0", stall); else nPass++;
  endtask

  task automatic test_d2s_single();
    int  stallCycles;
    bit  timedOut;
    int  obsRd;
    int  acc0;
    wr_t e;
    obsRd = obsSramQ.size();
    acc0  = acceptCnt;
    expSramQ.push_back({32'd24, dramInit(4)});
    applyStimulus(2'b01, 32'd16, 32'd24, 10'd1, 1'b0, stallCycles, timedOut);
    nChecks++; if (timedOut) $display("[TB] FAIL d2s1_timeout: got timeout expected completion"); else nPass++;
    nChecks++; if (stallCycles != 3) $display("[TB] FAIL d2s1_stall_cycles: got %0d expected 3", stallCycles); else nPass++;
    nChecks++; if (acceptCnt - acc0 != 1) $display("[TB] FAIL d2s1_dram_accepts: got %0d expected 1", acceptCnt - acc0); else nPass++;
    while (expSramQ.size() > 0) begin
      e = expSramQ.pop_front();
      nChecks++;
      if (obsRd >= obsSramQ.size()) $display("[TB] FAIL d2s1_sram_write: got none expected %h<=%h", e.addr, e.data);
      else if (obsSramQ[obsRd] !== e) $display("[TB] FAIL d2s1_sram_write: got %h<=%h expected %h<=%h", obsSramQ[obsRd].addr, obsSramQ[obsRd].data, e.addr, e.data);
      else nPass++;
      obsRd++;
    end
    nChecks++; if (obsSramQ.size() != obsRd) $display("[TB] FAIL d2s1_sram_count: got %0d writes expected %0d", obsSramQ.size(), obsRd); else nPass++;
    nChecks++; if (sramMem[6] !== dramInit(4)) $display("[TB] FAIL d2s1_sram_word6: got %h expected %h", sramMem[6], dramInit(4)); else nPass++;
  endtask

  task automatic test_s2d_backpressure();
    int  stallCycles;
    bit  timedOut;
    int  obsRd;
    int  stallRd;
    int  acc0;
    wr_t e;
    obsRd   = obsDramQ.size();
    stallRd = stallAddrQ.size();
    acc0    = acceptCnt;
    for (int i = 0; i < 4; i++) expDramQ.push_back({32'h100 + 32'(4 * i), sramInit(i)});
    readyAt = stallSeen + 2;
    applyStimulus(2'b10, 32'h0, 32'h100, 10'd4, 1'b0, stallCycles, timedOut);
    nChecks++; if (timedOut) $display("[TB] FAIL s2d_timeout: got timeout expected completion"); else nPass++;
    nChecks++; if (stallCycles != 7) $display("[TB] FAIL s2d_stall_cycles: got %0d expected 7", stallCycles); else nPass++;
    nChecks++; if (acceptCnt - acc0 != 4) $display("[TB] FAIL s2d_dram_accepts: got %0d expected 4", acceptCnt - acc0); else nPass++;
    while (expDramQ.size() > 0) begin
      e = expDramQ.pop_front();
      nChecks++;
      if (obsRd >= obsDramQ.size()) $display("[TB] FAIL s2d_dram_write: got none expected %h<=%h", e.addr, e.data);
      else if (obsDramQ[obsRd] !== e) $display("[TB] FAIL s2d_dram_write: got %h<=%h expected %h<=%h", obsDramQ[obsRd].addr, obsDramQ[obsRd].data, e.addr, e.data);
      else nPass++;
      obsRd++;
    end
    nChecks++; if (stallAddrQ.size() - stallRd != 2) $display("[TB] FAIL s2d_wait_cycles: got %0d expected 2", stallAddrQ.size() - stallRd); else nPass++;
    for (int i = stallRd; i < stallAddrQ.size(); i++) begin
      nChecks++; if (stallAddrQ[i] !== 32'h100) $display("[TB] FAIL s2d_wait_address: got %h expected 100", stallAddrQ[i]); else nPass++;
    end
  endtask

  task automatic test_width_zero();
    int stallCycles;
    bit timedOut;
    int req0;
    int sram0;
    req0  = reqCycles;
    sram0 = obsSramQ.size();
    applyStimulus(2'b01, 32'h10, 32'h20, 10'd0, 1'b0, stallCycles, timedOut);
    nChecks++; if (stallCycles != 1) $display("[TB] FAIL w0_stall_cycles: got %0d expected 1", stallCycles); else nPass++;
    nChecks++; if (reqCycles != req0) $display("[TB] FAIL w0_dramReq: got %0d request cycles expected 0", reqCycles - req0); else nPass++;
    nChecks++; if (obsSramQ.size() != sram0) $display("[TB] FAIL w0_sram_writes: got %0d expected 0", obsSramQ.size() - sram0); else nPass++;
  endtask

  task automatic test_reserved_cmd();
    int req0;
    int sram0;
    req0  = reqCycles;
    sram0 = obsSramQ.size();
    @(negedge clk);
    dmaCmd        = 2'b11;
    dmaSrcAddress = 32'h40;
    dmaDstAddress = 32'h80;
    dmaWidth      = 10'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      nChecks++; if (stall !== 1'b0) $display("[TB] FAIL cmd11_stall: got %b expected 0 (cycle %0d)", stall, c); else nPass++;
      @(negedge clk);
    end
    dmaCmd = 2'b00;
    @(negedge clk);
    nChecks++; if (reqCycles != req0) $display("[TB] FAIL cmd11_dramReq: got %0d request cycles expected 0", reqCycles - req0); else nPass++;
    nChecks++; if (obsSramQ.size() != sram0) $display("[TB] FAIL cmd11_sram_writes: got %0d expected 0", obsSramQ.size() - sram0); else nPass++;
  endtask

  task automatic test_core_write();
    int  stallCycles;
    bit  timedOut;
    int  obsRd;
    wr_t e;
    cpuSramAddress   = 32'h8;
    cpuSramWriteData = 32'hDEAD_BEEF;
    obsRd = obsSramQ.size();
    expSramQ.push_back({32'h80, dramInit(16)});
    expSramQ.push_back({32'h84, dramInit(17)});
    applyStimulus(2'b01, 32'h40, 32'h80, 10'd2, 1'b1, stallCycles, timedOut);
    nChecks++; if (stallCycles != 5) $display("[TB] FAIL corewr_stall_cycles: got %0d expected 5", stallCycles); else nPass++;
    while (expSramQ.size() > 0) begin
      e = expSramQ.pop_front();
      nChecks++;
      if (obsRd >= obsSramQ.size()) $display("[TB] FAIL corewr_sram_write: got none expected %h<=%h", e.addr, e.data);
      else if (obsSramQ[obsRd] !== e) $display("[TB] FAIL corewr_sram_write: got %h<=%h expected %h<=%h", obsSramQ[obsRd].addr, obsSramQ[obsRd].data, e.addr, e.data);
      else nPass++;
      obsRd++;
    end
    nChecks++; if (obsSramQ.size() != obsRd) $display("[TB] FAIL corewr_blocked_count: got %0d writes expected %0d", obsSramQ.size(), obsRd); else nPass++;
    nChecks++; if (sramMem[2] !== sramInit(2)) $display("[TB] FAIL corewr_blocked_word2: got %h expected %h", sramMem[2], sramInit(2)); else nPass++;
    @(negedge clk);
    cpuSramWriteEnable = 1'b1;
    @(negedge clk);
    cpuSramWriteEnable = 1'b0;
    nChecks++; if (sramMem[2] !== 32'hDEAD_BEEF) $display("[TB] FAIL corewr_idle_word2: got %h expected deadbeef", sramMem[2]); else nPass++;
    nChecks++; if (obsSramQ.size() != obsRd + 1) $display("[TB] FAIL corewr_idle_count: got %0d writes expected %0d", obsSramQ.size(), obsRd + 1); else nPass++;
  endtask

  task automatic test_reset_abort();
    int  obsRd;
    int  waited;
    wr_t e;
    obsRd = obsSramQ.size();
    expSramQ.push_back({32'h300, dramInit(128)});
    expSramQ.push_back({32'h304, dramInit(129)});
    @(negedge clk);
    dmaCmd        = 2'b01;
    dmaSrcAddress = 32'h200;
    dmaDstAddress = 32'h300;
    dmaWidth      = 10'd4;
    @(negedge clk);
    dmaCmd = 2'b00;
    waited = 0;
    while (obsSramQ.size() - obsRd < 2 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    nChecks++; if (waited >= 40) $display("[TB] FAIL abort_timeout: got %0d writes expected 2", obsSramQ.size() - obsRd); else nPass++;
    reset = 1'b0;
    #1;
    nChecks++; if (stall !== 1'b0) $display("[TB] FAIL abort_stall: got %b expected 0", stall); else nPass++;
    nChecks++; if (dramReq !== 1'b0) $display("[TB] FAIL abort_dramReq: got %b expected 0", dramReq); else nPass++;
    nChecks++; if (dramAddress !== 32'h0) $display("[TB] FAIL abort_dramAddress: got %h expected 0", dramAddress); else nPass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    nChecks++; if (stall !== 1'b0 || dramReq !== 1'b0) $display("[TB] FAIL abort_stays_idle: got stall=%b dramReq=%b expected 0/0", stall, dramReq); else nPass++;
    while (expSramQ.size() > 0) begin
      e = expSramQ.pop_front();
      nChecks++;
      if (obsRd >= obsSramQ.size()) $display("[TB] FAIL abort_sram_write: got none expected %h<=%h", e.addr, e.data);
      else if (obsSramQ[obsRd] !== e) $display("[TB] FAIL abort_sram_write: got %h<=%h expected %h<=%h", obsSramQ[obsRd].addr, obsSramQ[obsRd].data, e.addr, e.data);
      else nPass++;
      obsRd++;
    end
    nChecks++; if (obsSramQ.size() != obsRd) $display("[TB] FAIL abort_sram_count: got %0d writes expected %0d", obsSramQ.size(), obsRd); else nPass++;
    nChecks++; if (sramMem[194] !== sramInit(194)) $display("[TB] FAIL abort_word2: got %h expected %h", sramMem[194], sramInit(194)); else nPass++;
    nChecks++; if (sramMem[195] !== sramInit(195)) $display("[TB] FAIL abort_word3: got %h expected %h", sramMem[195], sramInit(195)); else nPass++;
  endtask

  initial begin
    test_reset();
    test_d2s_single();
    test_s2d_backpressure();
    test_width_zero();
    test_reserved_cmd();
    test_core_write();
    test_reset_abort();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
